// File: rtl/seq_div16.sv
// -----------------------------------------------------------------------------
// seq_div16 : multi-cycle unsigned restoring radix-2 divider
//
// Each clock in RUN performs one shift/trial-subtract step. A WIDTH-bit
// division therefore takes WIDTH iterations. Results are announced with a
// single-cycle done pulse and are then held until the next completion.
// A zero divisor skips iteration entirely: done is raised on the next cycle
// with quotient = all ones, remainder = dividend and div_by_zero = 1.
//
// Ports
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   start        in   request a division (accepted when busy = 0)
//   dividend     in   numerator, sampled on the accepting edge
//   divisor      in   denominator, sampled on the accepting edge
//   busy         out  operation in progress (state RUN)
//   done         out  one-cycle result-valid pulse
//   quotient     out  unsigned quotient (held between completions)
//   remainder    out  unsigned remainder (held between completions)
//   div_by_zero  out  last completed operation had a zero divisor
//   state_dbg    out  current FSM state, for observation
//
// Handshake: start is a request qualified by busy. On a rising edge where
// start = 1 and busy = 0, the operands are captured and the operation is
// committed; start while busy = 1 is ignored. done = 1 marks the single cycle
// in which quotient/remainder/div_by_zero first present the new result.
// -----------------------------------------------------------------------------
module seq_div16 #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero,
   output logic [1:0]       state_dbg
);

   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_next;

   logic [WIDTH-1:0] r_div;        // latched divisor
   logic [WIDTH-1:0] r_rem;        // partial remainder
   logic [WIDTH-1:0] r_quo;        // dividend bits shifting out, quotient bits shifting in
   logic [CW-1:0]    r_cnt;        // iterations still to perform
   logic [WIDTH-1:0] r_quotient;
   logic [WIDTH-1:0] r_remainder;
   logic             r_dbz;

   logic [WIDTH:0]   w_shift;
   logic [WIDTH:0]   w_trial;
   logic             w_borrow;
   logic [WIDTH-1:0] w_rem_next;
   logic [WIDTH-1:0] w_quo_next;
   logic             w_last_iter;
   logic             w_div_zero;

   // One restoring step. The shifted remainder can reach WIDTH+1 bits, so
   // the trial subtract is carried out at WIDTH+1 bits; its MSB is the
   // borrow, which is set exactly when the divisor does not fit.
   always_comb begin
      w_shift     = {r_rem, r_quo[WIDTH-1]};
      w_trial     = w_shift - {1'b0, r_div};
      w_borrow    = w_trial[WIDTH];
      w_rem_next  = w_borrow ? w_shift[WIDTH-1:0] : w_trial[WIDTH-1:0];
      w_quo_next  = {r_quo[WIDTH-2:0], ~w_borrow};
      w_last_iter = (r_cnt == CW'(1));
      w_div_zero  = (divisor == '0);
   end

   // Next-state logic
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (start) begin
               w_state_next = w_div_zero ? S_DONE : S_RUN;
            end else begin
               w_state_next = S_IDLE;
            end
         end
         S_RUN: begin
            if (w_last_iter) begin
               w_state_next = S_DONE;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Datapath. The visible result registers are written only on completion
   // (last iteration or zero-divisor accept), so they hold during RUN.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_div       <= '0;
         r_rem       <= '0;
         r_quo       <= '0;
         r_cnt       <= '0;
         r_quotient  <= '0;
         r_remainder <= '0;
         r_dbz       <= 1'b0;
      end else begin
         case (r_state)
            S_RUN: begin
               r_rem <= w_rem_next;
               r_quo <= w_quo_next;
               r_cnt <= r_cnt - CW'(1);
               if (w_last_iter) begin
                  r_quotient  <= w_quo_next;
                  r_remainder <= w_rem_next;
               end
            end
            default: begin
               if (start) begin
                  if (w_div_zero) begin
                     r_quotient  <= '1;
                     r_remainder <= dividend;
                     r_dbz       <= 1'b1;
                  end else begin
                     r_div <= divisor;
                     r_rem <= '0;
                     r_quo <= dividend;
                     r_cnt <= CW'(WIDTH);
                     r_dbz <= 1'b0;
                  end
               end
            end
         endcase
      end
   end

   assign busy        = (r_state == S_RUN);
   assign done        = (r_state == S_DONE);
   assign quotient    = r_quotient;
   assign remainder   = r_remainder;
   assign div_by_zero = r_dbz;
   assign state_dbg   = r_state;

endmodule

// File: tb/tb_seq_div16.sv
// -----------------------------------------------------------------------------
// tb_seq_div16 : bench for seq_div16
// Expected results come from plain / and % in model(); the driver pushes them
// on acceptance and an independent monitor pops them whenever done is seen.
// -----------------------------------------------------------------------------
module tb_seq_div16;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;
  logic [1:0]   state_dbg;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0 = 0;

  // {div_by_zero, remainder, quotient}
  logic [2*W:0] exp_q[$];
  logic [2*W-1:0] last_res = '0;

  seq_div16 #(.WIDTH(W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .dividend(dividend),
    .divisor(divisor),
    .busy(busy),
    .done(done),
    .quotient(quotient),
    .remainder(remainder),
    .div_by_zero(div_by_zero),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  function automatic logic [2*W:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] q;
    logic [W-1:0] r;
    if (b == 0) return {1'b1, a, {W{1'b1}}};
    q = a / b;
    r = a % b;
    return {1'b0, r, q};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Accept an operation: waits until not busy, holds start across one edge.
  task automatic issue_start(input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    n = 0;
    while (busy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("not_busy_before_start", {63'd0, busy}, 64'd0);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    exp_q.push_back(model(a, b));
    #1;
    t0 = cyc;
    start = 1'b0;
    check("busy_after_accept", {63'd0, busy}, {63'd0, (b != 0)});
  endtask

  // Wait (bounded) for done; verify latency counted from the accepting edge.
  task automatic wait_done(input int exp_lat);
    while (!done && (cyc - t0) < 40) begin
      @(posedge clk); #1;
    end
    check("done_seen", {63'd0, done}, 64'd1);
    check("latency", 64'(cyc - t0), 64'(exp_lat));
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b);
    issue_start(a, b);
    wait_done((b == 0) ? 0 : W);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [2*W:0] e;
    if (!rst_n) begin
      check("reset_outputs", {29'd0, busy, done, div_by_zero, quotient, remainder}, 64'd0);
      last_res = '0;
    end else if (done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got q=%0h r=%0h expected no result", quotient, remainder);
      end else begin
        e = exp_q.pop_front();
        check("result", {31'd0, div_by_zero, remainder, quotient}, {31'd0, e});
        check("busy_in_done", {63'd0, busy}, 64'd0);
      end
      last_res = {remainder, quotient};
    end else begin
      check("hold", {32'd0, remainder, quotient}, {32'd0, last_res});
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] a;
    logic [W-1:0] b;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // directed cases
    do_op(16'd100, 16'd7);
    do_op(16'hFFFF, 16'h0001);
    do_op(16'hFFFF, 16'hFFFF);
    do_op(16'd3, 16'd10);
    do_op(16'd5, 16'd0);
    do_op(16'd0, 16'd1);

    // start while busy is ignored; operands are not resampled
    @(posedge clk); #1;
    issue_start(16'd100, 16'd7);
    repeat (4) begin
      @(posedge clk); #1;
    end
    dividend = 16'd50;
    divisor  = 16'd5;
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    wait_done(W);
    // back-to-back: start issued during the done cycle
    do_op(16'd50, 16'd5);

    // reset in the middle of RUN aborts without a done pulse
    dividend = 16'd1000;
    divisor  = 16'd3;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) begin
      @(posedge clk); #1;
    end
    #1 rst_n = 1'b0;
    #1;
    check("abort_outputs", {29'd0, busy, done, div_by_zero, quotient, remainder}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_op(16'd9, 16'd4);

    // randomized regression, ~5% zero divisors, mixed gaps
    for (int i = 0; i < 2000; i++) begin
      a = W'($urandom);
      case ($urandom_range(0, 19))
        0:       b = '0;
        1, 2, 3: b = W'($urandom_range(1, 15));
        4, 5:    b = W'($urandom_range(1, 255));
        6:       b = a;
        default: b = W'($urandom);
      endcase
      do_op(a, b);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end

    repeat (3) @(posedge clk);
    #1;
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
